// File: rtl/counter_ctrl.sv
// counter_ctrl: button front end (sync + debounce + press detect),
// STOP/RUN/SET mode FSM, run prescaler and set-mode auto-repeat.
module counter_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int REP_CYCLES  = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch,
    input  logic       add,
    input  logic       deduct,
    input  logic       clr,
    output logic       cnt_inc,
    output logic       cnt_dec,
    output logic       cnt_clr,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REP_CYCLES + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYCLES);

    typedef enum logic [1:0] {
        STOP = 2'b00,
        RUN  = 2'b01,
        SET  = 2'b10
    } state_t;

    // bit order: 0 switch, 1 add, 2 deduct, 3 clr
    logic [3:0] btn_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] deb_q;
    logic [3:0] deb_d;
    logic [3:0] press_q;
    logic [3:0] press_d;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];

    logic sw_p;
    logic add_p;
    logic ded_p;
    logic clr_p;
    logic add_low;
    logic ded_low;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [RW-1:0] rep_q;
    logic [RW-1:0] rep_d;
    logic rep_on_q;
    logic rep_on_d;
    logic rep_dn_q;
    logic rep_dn_d;

    logic cnt_inc_q;
    logic cnt_inc_d;
    logic cnt_dec_q;
    logic cnt_dec_d;
    logic cnt_clr_q;
    logic cnt_clr_d;
    logic tick_q;
    logic tick_d;

    assign btn_raw = {clr, deduct, add, switch};

    assign sw_p    = press_q[0];
    assign add_p   = press_q[1];
    assign ded_p   = press_q[2];
    assign clr_p   = press_q[3];
    assign add_low = ~deb_q[1];
    assign ded_low = ~deb_q[2];

    // two-flop synchronizers; idle (released) level is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // debounce: adopt a new level after DEB_CYCLES straight cycles of it
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
        press_d = deb_q & ~deb_d;
    end

    // debounced levels, their counters and press-event pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q   <= '1;
            press_q <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // mode state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // mode transitions; clr beats switch
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = STOP;
        end else if (sw_p) begin
            unique case (state_q)
                STOP:    state_d = RUN;
                RUN:     state_d = SET;
                SET:     state_d = RUN;
                default: state_d = STOP;
            endcase
        end
    end

    // prescaler, auto-repeat timing and next values of the output pulses
    always_comb begin
        pre_d     = pre_q;
        hold_d    = '0;
        rep_d     = '0;
        rep_on_d  = 1'b0;
        rep_dn_d  = rep_dn_q;
        cnt_inc_d = 1'b0;
        cnt_dec_d = 1'b0;
        cnt_clr_d = 1'b0;
        tick_d    = 1'b0;
        if (clr_p) begin
            cnt_clr_d = 1'b1;
            pre_d     = '0;
        end else if (state_q == RUN) begin
            if (pre_q == PRE_LAST) begin
                pre_d     = '0;
                tick_d    = 1'b1;
                cnt_inc_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end else if (state_q == SET && !sw_p && !(add_low && ded_low)) begin
            if (add_p) begin
                cnt_inc_d = 1'b1;
                rep_on_d  = 1'b1;
                rep_dn_d  = 1'b0;
            end else if (ded_p) begin
                cnt_dec_d = 1'b1;
                rep_on_d  = 1'b1;
                rep_dn_d  = 1'b1;
            end else if (rep_on_q && (rep_dn_q ? ded_low : add_low)) begin
                rep_on_d = 1'b1;
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                    if (hold_d == HOLD_LAST) begin
                        cnt_inc_d = ~rep_dn_q;
                        cnt_dec_d = rep_dn_q;
                    end
                end else begin
                    hold_d = hold_q;
                    rep_d  = rep_q + RW'(1);
                    if (rep_d == REP_LAST) begin
                        rep_d     = '0;
                        cnt_inc_d = ~rep_dn_q;
                        cnt_dec_d = rep_dn_q;
                    end
                end
            end
        end
    end

    // datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            rep_on_q  <= 1'b0;
            rep_dn_q  <= 1'b0;
            cnt_inc_q <= 1'b0;
            cnt_dec_q <= 1'b0;
            cnt_clr_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            rep_on_q  <= rep_on_d;
            rep_dn_q  <= rep_dn_d;
            cnt_inc_q <= cnt_inc_d;
            cnt_dec_q <= cnt_dec_d;
            cnt_clr_q <= cnt_clr_d;
            tick_q    <= tick_d;
        end
    end

    assign cnt_inc = cnt_inc_q;
    assign cnt_dec = cnt_dec_q;
    assign cnt_clr = cnt_clr_q;
    assign tick    = tick_q;
    assign mode    = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scenarios plus random button traffic,
// every cycle checked against a behavioural model.
module tb_counter_ctrl;

    localparam int TD   = 10;
    localparam int DEB  = 3;
    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int HL   = DEB + 2;

    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_SET  = 2'b10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] btn = 4'b1111;

    logic cnt_inc;
    logic cnt_dec;
    logic cnt_clr;
    logic tick;
    logic [1:0] mode;

    counter_ctrl #(
        .TICK_DIV(TD),
        .DEB_CYCLES(DEB),
        .HOLD_CYCLES(HOLD),
        .REP_CYCLES(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switch(btn[0]),
        .add(btn[1]),
        .deduct(btn[2]),
        .clr(btn[3]),
        .cnt_inc(cnt_inc),
        .cnt_dec(cnt_dec),
        .cnt_clr(cnt_clr),
        .mode(mode),
        .tick(tick)
    );

    always #5 clk = ~clk;

    // behavioural model state
    logic hist [4][HL];
    logic m_deb [4];
    logic m_prs [4];
    logic [1:0] m_mode;
    int m_pre;
    int m_age;
    logic m_rep;
    logic m_rded;
    logic m_inc;
    logic m_dec;
    logic m_clr;
    logic m_tick;
    logic a_lo;
    logic d_lo;
    logic chg;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < HL; k++) hist[i][k] = 1'b1;
                m_deb[i] = 1'b1;
                m_prs[i] = 1'b0;
            end
            m_mode = ST_STOP;
            m_pre  = 0;
            m_age  = 0;
            m_rep  = 1'b0;
            m_rded = 1'b0;
            m_inc  = 1'b0;
            m_dec  = 1'b0;
            m_clr  = 1'b0;
            m_tick = 1'b0;
        end else begin
            m_inc  = 1'b0;
            m_dec  = 1'b0;
            m_clr  = 1'b0;
            m_tick = 1'b0;
            a_lo = !m_deb[1];
            d_lo = !m_deb[2];
            if (m_prs[3]) begin
                m_clr  = 1'b1;
                m_pre  = 0;
                m_rep  = 1'b0;
                m_mode = ST_STOP;
            end else begin
                if (m_mode == ST_RUN) begin
                    m_pre = (m_pre + 1) % TD;
                    if (m_pre == 0) begin
                        m_tick = 1'b1;
                        m_inc  = 1'b1;
                    end
                    m_rep = 1'b0;
                end else if (m_mode == ST_SET && !m_prs[0] && !(a_lo && d_lo)) begin
                    if (m_prs[1] || m_prs[2]) begin
                        m_rded = m_prs[2];
                        m_rep  = 1'b1;
                        m_age  = 0;
                        m_inc  = !m_rded;
                        m_dec  = m_rded;
                    end else if (m_rep && (m_rded ? d_lo : a_lo)) begin
                        m_age++;
                        if (m_age >= HOLD && (m_age - HOLD) % REP == 0) begin
                            m_inc = !m_rded;
                            m_dec = m_rded;
                        end
                    end else begin
                        m_rep = 1'b0;
                    end
                end else begin
                    m_rep = 1'b0;
                end
                if (m_prs[0]) m_mode = (m_mode == ST_RUN) ? ST_SET : ST_RUN;
            end
            // a button's level flips once its last DEB synchronized
            // samples (raw delayed by two) all disagree with it
            for (int i = 0; i < 4; i++) begin
                for (int k = HL - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = btn[i];
                chg = 1'b1;
                for (int k = 2; k < HL; k++) begin
                    if (hist[i][k] == m_deb[i]) chg = 1'b0;
                end
                m_prs[i] = 1'b0;
                if (chg) begin
                    m_prs[i] = m_deb[i];
                    m_deb[i] = !m_deb[i];
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int n_inc = 0;
    int n_dec = 0;
    int n_tick = 0;
    int cyc = 0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        tests++;
        if (mode !== m_mode || tick !== m_tick || cnt_inc !== m_inc ||
            cnt_dec !== m_dec || cnt_clr !== m_clr) begin
            fails++;
            $display("FAIL model_cmp cyc=%0d got mode=%0d tick=%b inc=%b dec=%b clr=%b want mode=%0d tick=%b inc=%b dec=%b clr=%b",
                     cyc, mode, tick, cnt_inc, cnt_dec, cnt_clr,
                     m_mode, m_tick, m_inc, m_dec, m_clr);
        end
        if (cnt_inc === 1'b1) n_inc++;
        if (cnt_dec === 1'b1) n_dec++;
        if (tick === 1'b1) n_tick++;
    endtask

    task automatic press(int b, int n);
        btn[b] = 1'b0;
        repeat (n) step();
        btn[b] = 1'b1;
    endtask

    task automatic wait_mode(logic [1:0] m, output int n);
        n = 0;
        while (mode !== m && n < 200) begin
            step();
            n++;
        end
        check("wait_mode", int'(mode), int'(m));
    endtask

    task automatic wait_tick(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (tick !== 1'b1 && k < 200);
        check("wait_tick", int'(tick), 1);
    endtask

    int n;
    int k;
    int first;
    int r;

    initial begin
        // reset state
        repeat (3) step();
        check("reset_mode", int'(mode), 0);
        check("reset_pulses", int'({cnt_inc, cnt_dec, cnt_clr, tick}), 0);
        reset = 1'b0;
        repeat (3) step();

        // STOP -> RUN, then one tick every TD cycles
        press(0, 5);
        wait_mode(ST_RUN, n);
        n_tick = 0;
        n_inc  = 0;
        first  = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (tick === 1'b1 && first == 0) first = i;
        end
        check("first_tick_latency", first, 10);
        check("ticks_in_50", n_tick, 5);
        check("inc_in_50", n_inc, 5);

        // RUN -> SET; glitch rejected, short press counts once
        press(0, 5);
        wait_mode(ST_SET, n);
        repeat (8) step();
        n_inc = 0;
        press(1, 2);
        repeat (8) step();
        check("glitch_inc", n_inc, 0);
        press(1, 4);
        repeat (12) step();
        check("short_add_inc", n_inc, 1);

        // long deduct hold: initial pulse plus repeats at 8,12,16,20
        n_inc = 0;
        n_dec = 0;
        press(2, 21);
        repeat (12) step();
        check("hold_dec", n_dec, 5);
        check("hold_inc", n_inc, 0);

        // prescaler held at 7 through SET, resumes without extra tick
        press(0, 5);
        wait_mode(ST_RUN, n);
        wait_tick(k);
        step();
        press(0, 5);
        wait_mode(ST_SET, n);
        repeat (30) step();
        press(0, 5);
        wait_mode(ST_RUN, n);
        wait_tick(k);
        check("resume_tick_latency", k, 3);

        // clr press lands on the wrap cycle: clear wins, tick dropped
        repeat (4) step();
        btn[3] = 1'b0;
        repeat (6) step();
        check("wrap_clr", int'(cnt_clr), 1);
        check("wrap_inc", int'(cnt_inc), 0);
        check("wrap_tick", int'(tick), 0);
        check("wrap_mode", int'(mode), 0);
        btn[3] = 1'b1;
        repeat (6) step();
        press(0, 5);
        wait_mode(ST_RUN, n);
        wait_tick(k);
        check("post_clr_tick_latency", k, 10);

        // reset in the middle of a SET auto-repeat
        press(0, 5);
        wait_mode(ST_SET, n);
        repeat (8) step();
        btn[2] = 1'b0;
        repeat (20) step();
        check("pre_reset_mode", int'(mode), 2);
        reset = 1'b1;
        #1;
        check("async_reset_mode", int'(mode), 0);
        check("async_reset_pulses", int'({cnt_inc, cnt_dec, cnt_clr, tick}), 0);
        repeat (3) step();
        reset = 1'b0;
        n_dec = 0;
        repeat (25) step();
        check("post_reset_dec", n_dec, 0);
        check("post_reset_mode", int'(mode), 0);
        btn[2] = 1'b1;
        repeat (8) step();

        // random button traffic
        for (int s = 0; s < 160; s++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                reset = 1'b0;
            end else begin
                btn[0] = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
                btn[1] = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
                btn[2] = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
                btn[3] = ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1;
                repeat ($urandom_range(1, 24)) step();
                if ($urandom_range(0, 1) == 1) btn = 4'b1111;
                repeat ($urandom_range(0, 12)) step();
            end
        end
        btn = 4'b1111;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
